// File: rtl/multiplier_n_seq.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_n_seq
// Brief    : Sequential unsigned radix-2 shift-and-add multiplier. It takes N-bit
//            operands on a start pulse and retires one multiplier bit per clock.
//            A 2N-bit product is presented with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module multiplier_n_seq #(
  parameter int N = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           done
);

  // Iteration counter must hold the value N without wrapping.
  localparam int              c_CNT_W = $clog2(N + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  // Multiplicand pre-shifted by the current count. Shifting it one place per
  // iteration is equivalent to A << count without a variable shifter.
  logic [2*N-1:0]       r_a;
  logic [N-1:0]         r_b;
  logic [2*N-1:0]       r_acc;
  logic [2*N-1:0]       r_product;
  logic [c_CNT_W-1:0]   r_count;
  logic [2*N-1:0]       w_addend;
  logic [2*N-1:0]       w_acc_sum;
  logic                 w_last;

  assign w_last    = (r_count == c_LAST);
  assign w_addend  = r_b[0] ? r_a : '0;
  assign w_acc_sum = r_acc + w_addend;

  // State register; reset returns to IDLE at any time, including mid-run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode: fixed N-cycle run, then a single DONE cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture operands on accept, add/shift once per RUN cycle,
  // and publish the product only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= {{N{1'b0}}, multiplicand};
            r_b     <= multiplier;
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_sum;
          r_a     <= r_a << 1;
          r_b     <= r_b >> 1;
          r_count <= r_count + c_CNT_W'(1);
          if (w_last) begin
            r_product <= w_acc_sum;
          end
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_multiplier_n_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiplier_n_seq
// Brief    : Scoreboard bench for multiplier_n_seq. Directed and random N=6 traffic,
//            plus independent N=4 and N=8 random sweeps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiplier_n_seq;

  localparam int N = 6;

  logic           clk;
  logic           rst_n;
  logic           sw_rst_n;
  logic           start;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic [2*N-1:0] product;
  logic           busy;
  logic           done;

  int n_tests;
  int n_fail;

  logic [2*N-1:0] exp_q[$];
  logic [2*N-1:0] last_product;
  logic           prev_rst_n;
  logic           prev_done;

  multiplier_n_seq #(.N(N)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Main monitor: pops the scoreboard on done, checks pulse width and product hold.
  always @(negedge clk) begin
    if (rst_n && prev_rst_n) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected done", longint'(product), 0);
        end else begin
          logic [2*N-1:0] e;
          e = exp_q.pop_front();
          chk(product == e, "product", longint'(product), longint'(e));
        end
        chk(!prev_done, "done width", longint'(prev_done), 0);
      end else begin
        chk(product == last_product, "product hold", longint'(product), longint'(last_product));
      end
    end
    last_product = product;
    prev_rst_n   = rst_n;
    prev_done    = done;
  end

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || done) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk(1'b0, "idle timeout", longint'(t), 50);
  endtask

  // Issue one operation; returns at a negedge one cycle after done.
  task automatic run_op(input int a, input int b, input string name, input int hold);
    int k;
    wait_idle();
    mcand  = N'(a);
    mplier = N'(b);
    start  = 1'b1;
    exp_q.push_back((2*N)'(a * b));
    @(negedge clk);
    start  = 1'b0;
    mcand  = N'($urandom);
    mplier = N'($urandom);
    chk(busy === 1'b1, {name, " busy"}, longint'(busy), 1);
    k = 0;
    while (!done && k < 20) begin
      if (hold >= 0 && k == N - 1)
        chk(product == (2*N)'(hold), {name, " old hold"}, longint'(product), longint'(hold));
      @(negedge clk);
      k++;
    end
    chk(k == N, {name, " latency"}, longint'(k), longint'(N));
    @(negedge clk);
    chk(!busy && !done, {name, " idle after"}, longint'({busy, done}), 0);
  endtask

  // -------------------------------------------------------------------------
  // Independent random sweeps at other widths, sharing the clock and counters.
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int W = (g == 0) ? 4 : 8;

    logic           s_start;
    logic [W-1:0]   s_a;
    logic [W-1:0]   s_b;
    logic [2*W-1:0] s_p;
    logic           s_busy;
    logic           s_done;
    logic           s_prev_done;
    logic [2*W-1:0] q[$];
    int             n_done;
    int             n_acc;
    bit             fin;

    multiplier_n_seq #(.N(W)) u_dut (
      .clk          (clk),
      .rst_n        (sw_rst_n),
      .start        (s_start),
      .multiplicand (s_a),
      .multiplier   (s_b),
      .product      (s_p),
      .busy         (s_busy),
      .done         (s_done)
    );

    // Sweep stimulus: corner operands first, then uniform random pairs.
    initial begin
      int ai;
      int bi;
      int t;
      fin     = 1'b0;
      n_done  = 0;
      n_acc   = 0;
      s_start = 1'b0;
      s_a     = '0;
      s_b     = '0;
      @(posedge sw_rst_n);
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        t = 0;
        while (s_busy && t < 50) begin
          @(negedge clk);
          t++;
        end
        if (t >= 50) begin
          chk(1'b0, "sweep idle timeout", longint'(W), 0);
          break;
        end
        case (i)
          0:       begin ai = 0;            bi = (1 << W) - 1; end
          1:       begin ai = (1 << W) - 1; bi = (1 << W) - 1; end
          2:       begin ai = (1 << W) - 1; bi = 0;            end
          default: begin
            ai = int'($urandom_range(0, (1 << W) - 1));
            bi = int'($urandom_range(0, (1 << W) - 1));
          end
        endcase
        s_a     = W'(ai);
        s_b     = W'(bi);
        s_start = 1'b1;
        q.push_back((2*W)'(ai * bi));
        n_acc++;
        @(negedge clk);
        s_start = 1'b0;
        s_a     = W'($urandom);
        s_b     = W'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      t = 0;
      while ((s_busy || q.size() != 0) && t < 50) begin
        @(negedge clk);
        t++;
      end
      @(negedge clk);
      chk(n_done == n_acc, "sweep done count", longint'(n_done), longint'(n_acc));
      fin = 1'b1;
    end

    // Sweep monitor.
    always @(negedge clk) begin
      if (sw_rst_n && s_done) begin
        n_done++;
        if (q.size() == 0) begin
          chk(1'b0, "sweep unexpected done", longint'(s_p), 0);
        end else begin
          logic [2*W-1:0] e;
          e = q.pop_front();
          chk(s_p == e, "sweep product", longint'(s_p), longint'(e));
        end
        chk(!s_prev_done, "sweep done width", longint'(s_prev_done), 0);
      end
      s_prev_done = s_done;
    end
  end

  // Watchdog: never let the run hang.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Main N=6 sequence.
  initial begin
    int k;
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    sw_rst_n     = 1'b0;
    start        = 1'b0;
    mcand        = '0;
    mplier       = '0;
    last_product = '0;
    prev_rst_n   = 1'b0;
    prev_done    = 1'b0;
    repeat (3) @(negedge clk);
    chk(product == '0, "reset product", longint'(product), 0);
    chk(!busy, "reset busy", longint'(busy), 0);
    chk(!done, "reset done", longint'(done), 0);
    rst_n    = 1'b1;
    sw_rst_n = 1'b1;

    // Basic operation and latency.
    run_op(15, 5, "t1", -1);
    // Max operands, then a result that must not disturb the held value early.
    run_op(63, 63, "t2a", -1);
    run_op(14, 7, "t2b", 3969);
    // Zero operands: same fixed latency.
    run_op(0, 40, "t3a", -1);
    run_op(40, 0, "t3b", -1);

    // Starts during RUN and DONE are ignored.
    wait_idle();
    mcand  = 6'd9;
    mplier = 6'd3;
    start  = 1'b1;
    exp_q.push_back(12'd27);
    @(negedge clk);
    start  = 1'b0;
    mcand  = 6'd2;
    mplier = 6'd2;
    @(negedge clk);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    k = 2;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(k == N, "t4 latency", longint'(k), longint'(N));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk(!busy, "t4 idle after done", longint'(busy), 0);
    repeat (3) @(negedge clk);
    chk(!busy, "t4 no queued start", longint'(busy), 0);
    run_op(2, 2, "t4b", -1);

    // Asynchronous reset mid-run clears outputs without a clock edge.
    wait_idle();
    mcand  = 6'd33;
    mplier = 6'd21;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk(product == '0, "t5 async product", longint'(product), 0);
    chk(!busy, "t5 async busy", longint'(busy), 0);
    chk(!done, "t5 async done", longint'(done), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_op(7, 6, "t5b", -1);

    // start held high: restarts with operands present at the first IDLE edge.
    wait_idle();
    mcand  = 6'd5;
    mplier = 6'd11;
    start  = 1'b1;
    exp_q.push_back(12'd55);
    @(negedge clk);
    mcand  = 6'd12;
    mplier = 6'd3;
    exp_q.push_back(12'd36);
    k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    chk(busy === 1'b1, "held restart busy", longint'(busy), 1);
    k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(k == N, "held restart latency", longint'(k), longint'(N));

    // Random N=6 traffic.
    for (int i = 0; i < 200; i++) begin
      run_op(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), "rand6", -1);
    end
    wait_idle();
    chk(exp_q.size() == 0, "scoreboard drained", longint'(exp_q.size()), 0);

    k = 0;
    while (!(g_sweep[0].fin && g_sweep[1].fin) && k < 40000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40000) chk(1'b0, "sweep finish timeout", longint'(k), 40000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
